imem_loadable: RTL and testbench

Parametrised, loadable instruction memory for the 8-bit processor; successor to the fixed-content instruction ROM. It holds up to DEPTH instruction words written at runtime through a sequential load port, then serves fetches through a registered, back-pressurable fetch port with one-cycle latency. Fetches beyond the loaded program length return a zero word with a fault flag. It sits between the program loader/debug port and the processor's fetch/decode stage.

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_loadable_if.sv | 38 +++
 rtl/imem_ram.sv | 32 +++
 rtl/imem_loadable.sv | 130 +++++++++++++
 tb/tb_imem_loadable.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// The FSM state enum and the word returned on a faulting fetch.
package imem_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Wide enough for any DATA_W; users slice to their word width.
  localparam logic [255:0] NOP_WORD = '0;

endpackage

// File: rtl/imem_loadable_if.sv
// Load-port and fetch-port bundle for imem_loadable.
// The master side is the loader/fetch stage; the slave side is the memory.
interface imem_loadable_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);

  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              busy;
  logic [ADDR_W:0]   load_count;
  logic              load_ovf;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              instr_valid;
  logic [DATA_W-1:0] instruction;
  logic              fault;
  logic              instr_ready;

  modport master (
    output load_start, load_valid, load_data, load_done,
    output fetch_req, fetch_addr, instr_ready,
    input  busy, load_count, load_ovf,
    input  fetch_ready, instr_valid, instruction, fault
  );

  modport slave (
    input  load_start, load_valid, load_data, load_done,
    input  fetch_req, fetch_addr, instr_ready,
    output busy, load_count, load_ovf,
    output fetch_ready, instr_valid, instruction, fault
  );

endinterface

// File: rtl/imem_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with
// registered read data that only updates when a read is enabled.
module imem_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // No reset here so the array and read register map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem_reg[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: sequential load port, one-cycle registered
// fetch port with back-pressure, and fault flag beyond the program length.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_loadable_if.slave   bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              ovf_reg, ovf_next;
  logic              valid_reg, valid_next;
  logic              hit_reg, hit_next;
  logic              fault_reg, fault_next;

  logic              fetch_ready;
  logic              accept;
  logic              in_range;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
      hit_reg   <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      valid_reg <= valid_next;
      hit_reg   <= hit_next;
      fault_reg <= fault_next;
    end
  end

  // The load pointer always equals the word count, so one register serves both.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    valid_next  = valid_reg;
    hit_next    = hit_reg;
    fault_next  = fault_reg;
    ram_we      = 1'b0;
    ram_re      = 1'b0;

    fetch_ready = (state_reg == ST_RUN) && !bus.load_start &&
                  (!valid_reg || bus.instr_ready);
    accept      = bus.fetch_req && fetch_ready;
    in_range    = {1'b0, bus.fetch_addr} < count_reg;

    case (state_reg)
      ST_RUN: begin
        if (bus.load_start) begin
          state_next = ST_LOAD;
          count_next = '0;
          ovf_next   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (bus.load_start) begin
          count_next = '0;
          ovf_next   = 1'b0;
        end else begin
          // A write in the load_done cycle still lands before returning to RUN.
          if (bus.load_valid) begin
            if (count_reg < DEPTH_C) begin
              ram_we     = 1'b1;
              count_next = count_reg + 1'b1;
            end else begin
              ovf_next = 1'b1;
            end
          end
          if (bus.load_done) begin
            state_next = ST_RUN;
          end
        end
      end
      default: state_next = ST_RUN;
    endcase

    // Out-of-range fetches skip the RAM read; hit_reg selects the zero word.
    if (bus.load_start) begin
      valid_next = 1'b0;
    end else if (accept) begin
      valid_next = 1'b1;
      hit_next   = in_range;
      fault_next = !in_range;
      ram_re     = in_range;
    end else if (bus.instr_ready) begin
      valid_next = 1'b0;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (count_reg[ADDR_W-1:0]),
    .wdata (bus.load_data),
    .re    (ram_re),
    .raddr (bus.fetch_addr),
    .rdata (ram_rdata)
  );

  assign bus.busy        = (state_reg == ST_LOAD);
  assign bus.load_count  = count_reg;
  assign bus.load_ovf    = ovf_reg;
  assign bus.fetch_ready = fetch_ready;
  assign bus.instr_valid = valid_reg;
  assign bus.instruction = hit_reg ? ram_rdata : NOP_WORD[DATA_W-1:0];
  assign bus.fault       = fault_reg;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: a full-depth instance for load/fetch/stall
// and reset cases, plus a DEPTH=4 instance for the overflow case.
module tb_imem_loadable;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  imem_loadable_if #(.DATA_W(16), .ADDR_W(8)) bus_m ();
  imem_loadable_if #(.DATA_W(16), .ADDR_W(8)) bus_s ();

  imem_loadable #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  imem_loadable #(.DATA_W(16), .ADDR_W(8), .DEPTH(4)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  logic [15:0] prog [8] = '{16'h0123, 16'h1456, 16'h2789, 16'h3abc,
                            16'h4def, 16'h5f01, 16'h6234, 16'h7442};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("check %s: got=0x%0h ok", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_m.load_start = 0; bus_m.load_valid = 0; bus_m.load_data = '0; bus_m.load_done = 0;
    bus_m.fetch_req = 0; bus_m.fetch_addr = '0; bus_m.instr_ready = 1;
    bus_s.load_start = 0; bus_s.load_valid = 0; bus_s.load_data = '0; bus_s.load_done = 0;
    bus_s.fetch_req = 0; bus_s.fetch_addr = '0; bus_s.instr_ready = 1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle_inputs();

    // Reset values
    #2;
    chk("rst_busy", 32'(bus_m.busy), 32'h0);
    chk("rst_count", 32'(bus_m.load_count), 32'h0);
    chk("rst_ovf", 32'(bus_m.load_ovf), 32'h0);
    chk("rst_valid", 32'(bus_m.instr_valid), 32'h0);
    chk("rst_instr", 32'(bus_m.instruction), 32'h0);
    chk("rst_fault", 32'(bus_m.fault), 32'h0);
    #10 rst_n = 1'b1;
    step();

    // Fetch before any load faults
    bus_m.fetch_req = 1; bus_m.fetch_addr = 8'd0;
    #1;
    chk("empty_ready", 32'(bus_m.fetch_ready), 32'h1);
    step();
    bus_m.fetch_req = 0;
    chk("empty_valid", 32'(bus_m.instr_valid), 32'h1);
    chk("empty_fault", 32'(bus_m.fault), 32'h1);
    chk("empty_instr", 32'(bus_m.instruction), 32'h0);

    // Load 8 words
    bus_m.load_start = 1;
    step();
    bus_m.load_start = 0;
    chk("load_busy", 32'(bus_m.busy), 32'h1);
    chk("load_valid_flushed", 32'(bus_m.instr_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      bus_m.load_valid = 1; bus_m.load_data = prog[i];
      step();
    end
    bus_m.load_valid = 0; bus_m.load_done = 1;
    step();
    bus_m.load_done = 0;
    chk("done_busy", 32'(bus_m.busy), 32'h0);
    chk("done_count", 32'(bus_m.load_count), 32'd8);
    chk("done_ovf", 32'(bus_m.load_ovf), 32'h0);

    // Back-to-back fetch 0..8
    bus_m.fetch_req = 1; bus_m.instr_ready = 1;
    for (int i = 0; i < 9; i++) begin
      bus_m.fetch_addr = 8'(i);
      step();
      chk($sformatf("b2b_valid_%0d", i), 32'(bus_m.instr_valid), 32'h1);
      chk($sformatf("b2b_instr_%0d", i), 32'(bus_m.instruction), (i < 8) ? 32'(prog[i]) : 32'h0);
      chk($sformatf("b2b_fault_%0d", i), 32'(bus_m.fault), (i < 8) ? 32'h0 : 32'h1);
    end
    bus_m.fetch_req = 0;
    step();
    chk("drain_valid", 32'(bus_m.instr_valid), 32'h0);

    // Stall for 3 cycles, then release
    bus_m.instr_ready = 0; bus_m.fetch_req = 1; bus_m.fetch_addr = 8'd2;
    step();
    bus_m.fetch_addr = 8'd5;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_ready_%0d", i), 32'(bus_m.fetch_ready), 32'h0);
      step();
      chk($sformatf("stall_instr_%0d", i), 32'(bus_m.instruction), 32'(prog[2]));
      chk($sformatf("stall_valid_%0d", i), 32'(bus_m.instr_valid), 32'h1);
    end
    bus_m.instr_ready = 1;
    #1;
    chk("release_ready", 32'(bus_m.fetch_ready), 32'h1);
    step();
    chk("release_instr", 32'(bus_m.instruction), 32'(prog[5]));
    bus_m.fetch_req = 0;
    step();

    // load_start flushes a pending word; write and done in the same cycle
    bus_m.instr_ready = 0; bus_m.fetch_req = 1; bus_m.fetch_addr = 8'd1;
    step();
    chk("pend_valid", 32'(bus_m.instr_valid), 32'h1);
    bus_m.fetch_req = 0; bus_m.load_start = 1;
    #1;
    chk("pend_start_ready", 32'(bus_m.fetch_ready), 32'h0);
    step();
    bus_m.load_start = 0;
    chk("flush_valid", 32'(bus_m.instr_valid), 32'h0);
    bus_m.load_valid = 1; bus_m.load_data = 16'ha001;
    step();
    bus_m.load_data = 16'ha002;
    step();
    bus_m.load_data = 16'ha003; bus_m.load_done = 1;
    step();
    bus_m.load_valid = 0; bus_m.load_done = 0;
    chk("wd_busy", 32'(bus_m.busy), 32'h0);
    chk("wd_count", 32'(bus_m.load_count), 32'd3);
    bus_m.instr_ready = 1; bus_m.fetch_req = 1; bus_m.fetch_addr = 8'd2;
    step();
    chk("wd_instr2", 32'(bus_m.instruction), 32'ha003);
    chk("wd_fault2", 32'(bus_m.fault), 32'h0);
    bus_m.fetch_addr = 8'd3;
    step();
    chk("wd_instr3", 32'(bus_m.instruction), 32'h0);
    chk("wd_fault3", 32'(bus_m.fault), 32'h1);
    bus_m.fetch_req = 0;
    step();

    // DEPTH=4 overflow
    bus_s.load_start = 1;
    step();
    bus_s.load_start = 0;
    for (int i = 0; i < 6; i++) begin
      bus_s.load_valid = 1; bus_s.load_data = 16'(16'hb000 + i);
      step();
    end
    bus_s.load_valid = 0;
    chk("ovf_count", 32'(bus_s.load_count), 32'd4);
    chk("ovf_flag", 32'(bus_s.load_ovf), 32'h1);
    bus_s.load_start = 1;
    step();
    bus_s.load_start = 0;
    chk("restart_ovf", 32'(bus_s.load_ovf), 32'h0);
    chk("restart_count", 32'(bus_s.load_count), 32'h0);
    chk("restart_busy", 32'(bus_s.busy), 32'h1);
    bus_s.load_done = 1;
    step();
    bus_s.load_done = 0;

    // Asynchronous reset mid-load
    bus_m.load_start = 1;
    step();
    bus_m.load_start = 0;
    bus_m.load_valid = 1; bus_m.load_data = 16'hc001;
    step();
    bus_m.load_data = 16'hc002;
    step();
    bus_m.load_valid = 0;
    chk("preasync_count", 32'(bus_m.load_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", 32'(bus_m.load_count), 32'h0);
    chk("async_busy", 32'(bus_m.busy), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    bus_m.fetch_req = 1; bus_m.fetch_addr = 8'd0;
    step();
    bus_m.fetch_req = 0;
    chk("post_rst_valid", 32'(bus_m.instr_valid), 32'h1);
    chk("post_rst_fault", 32'(bus_m.fault), 32'h1);
    chk("post_rst_instr", 32'(bus_m.instruction), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
